// File: rtl/data_demux.sv
// Serial-to-parallel demux with training-word alignment (HUNT/CHECK/LOCKED) and bit slip.
// Latency: dout/dout_valid load on the edge after the last bit of a word is accepted.
// Backpressure: none; din_valid gaps freeze the datapath, and slips drop one valid bit each.
module data_demux #(
    parameter int                 N_LANES   = 4,
    parameter logic [N_LANES-1:0] ALIGN_PAT = N_LANES'(4'b1010),
    parameter int                 LOCK_CNT  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_valid,
    input  logic               slip,
    input  logic               realign,
    output logic [N_LANES-1:0] dout,
    output logic               dout_valid,
    output logic               locked
);
    localparam int            CW     = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam logic [CW-1:0] LAST   = CW'(N_LANES - 1);
    localparam logic [7:0]    LOCK_N = 8'(LOCK_CNT);

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [N_LANES-1:0] stage;
    logic [N_LANES-1:0] word;
    logic [7:0]         match_cnt, match_nxt;
    logic               slip_pend, slip_q, slip_edge;
    logic               accept, word_done, fsm_slip;

    assign accept    = din_valid & ~slip_pend;
    assign word_done = accept & (cnt == LAST);
    assign word      = {din, stage[N_LANES-2:0]};
    // A held slip request only drops one bit: act on its first valid cycle.
    assign slip_edge = slip & ~slip_q;
    assign locked    = (state == LOCKED);

    always_comb begin
        state_nxt = state;
        match_nxt = match_cnt;
        fsm_slip  = 1'b0;
        if (realign) begin
            state_nxt = HUNT;
            match_nxt = 8'd0;
        end else if (word_done) begin
            case (state)
                HUNT: begin
                    if (word == ALIGN_PAT) begin
                        match_nxt = 8'd1;
                        state_nxt = (LOCK_N <= 8'd1) ? LOCKED : CHECK;
                    end else begin
                        fsm_slip = 1'b1;
                    end
                end
                CHECK: begin
                    if (word == ALIGN_PAT) begin
                        match_nxt = match_cnt + 8'd1;
                        if (match_nxt >= LOCK_N)
                            state_nxt = LOCKED;
                    end else begin
                        state_nxt = HUNT;
                        match_nxt = 8'd0;
                        fsm_slip  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            match_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            match_cnt <= match_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            stage      <= '0;
            slip_pend  <= 1'b0;
            slip_q     <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (din_valid)
                slip_q <= slip;
            if (realign) begin
                cnt       <= '0;
                stage     <= '0;
                slip_pend <= 1'b0;
            end else if (din_valid) begin
                if (slip_pend) begin
                    slip_pend <= 1'b0;
                end else begin
                    stage[cnt] <= din;
                    cnt        <= cnt + CW'(1);
                    slip_pend  <= slip_edge | fsm_slip;
                    if (word_done) begin
                        dout       <= word;
                        dout_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_data_demux.sv
// Directed bench for data_demux: vector table plus hand-written realign, reset and slip sequences.
module tb_data_demux;
    logic       clk = 1'b0;
    logic       rst, din, din_valid, slip, realign;
    logic [3:0] dout;
    logic       dout_valid, locked;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       rst, v, d, s, ra;
        logic [3:0] edout;
        logic       edv, elk;
    } vec_t;

    vec_t tbl[$];

    data_demux dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .slip(slip),
        .realign(realign), .dout(dout), .dout_valid(dout_valid), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got dout/vld/lock=%b expected %b", name, act, exp);
        end
    endtask

    task automatic push(input logic r, input logic v, input logic d, input logic s, input logic ra,
                        input logic [3:0] edout, input logic edv, input logic elk);
        vec_t t;
        t.rst = r; t.v = v; t.d = d; t.s = s; t.ra = ra;
        t.edout = edout; t.edv = edv; t.elk = elk;
        tbl.push_back(t);
    endtask

    // Four bits of w, LSB first; the last loads dout=w with a valid pulse.
    task automatic push_word(input logic [3:0] w, input logic [3:0] prev,
                             input logic lk_mid, input logic lk_end);
        for (int i = 0; i < 4; i++)
            push(1'b0, 1'b1, w[i], 1'b0, 1'b0, (i == 3) ? w : prev, i == 3, (i == 3) ? lk_end : lk_mid);
    endtask

    task automatic step(input logic v, input logic d, input logic s, input logic ra,
                        input logic [3:0] edout, input logic edv, input logic elk, input string name);
        din_valid = v; din = d; slip = s; realign = ra;
        @(posedge clk);
        #1;
        chk(name, {dout, dout_valid, locked}, {edout, edv, elk});
    endtask

    initial begin
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; slip = 1'b0; realign = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {dout, dout_valid, locked}, 6'b0);
        rst = 1'b0;

        push_word(4'b1010, 4'b0000, 1'b0, 1'b0);
        // valid toggling: bits 0,1,0,1 interleaved with idle cycles carrying junk
        push(0, 1, 0, 0, 0, 4'b1010, 0, 0);
        push(0, 0, 1, 0, 0, 4'b1010, 0, 0);
        push(0, 1, 1, 0, 0, 4'b1010, 0, 0);
        push(0, 0, 0, 0, 0, 4'b1010, 0, 0);
        push(0, 1, 0, 0, 0, 4'b1010, 0, 0);
        push(0, 0, 0, 0, 0, 4'b1010, 0, 0);
        push(0, 1, 1, 0, 0, 4'b1010, 1, 0);
        push(1, 0, 0, 0, 0, 4'b0000, 0, 0);
        // training stream offset by one bit: mismatch, one bit dropped, then four matches
        push_word(4'b0101, 4'b0000, 1'b0, 1'b0);
        push(0, 1, 1, 0, 0, 4'b0101, 0, 0);
        push_word(4'b1010, 4'b0101, 1'b0, 1'b0);
        push_word(4'b1010, 4'b1010, 1'b0, 1'b0);
        push_word(4'b1010, 4'b1010, 1'b0, 1'b0);
        push_word(4'b1010, 4'b1010, 1'b0, 1'b1);
        push_word(4'b1111, 4'b1010, 1'b1, 1'b1);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; din_valid = tbl[i].v; din = tbl[i].d;
            slip = tbl[i].s; realign = tbl[i].ra;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), {dout, dout_valid, locked},
                {tbl[i].edout, tbl[i].edv, tbl[i].elk});
        end
        rst = 1'b0;

        // realign on the 4th bit while locked
        step(1, 0, 0, 0, 4'b1111, 0, 1, "lk_b0");
        step(1, 1, 0, 0, 4'b1111, 0, 1, "lk_b1");
        step(1, 0, 0, 0, 4'b1111, 0, 1, "lk_b2");
        step(1, 1, 0, 1, 4'b1111, 0, 0, "realign_suppress");
        step(1, 1, 0, 0, 4'b1111, 0, 0, "ra_b0");
        step(1, 1, 0, 0, 4'b1111, 0, 0, "ra_b1");
        step(1, 0, 0, 0, 4'b1111, 0, 0, "ra_b2");
        step(1, 0, 0, 0, 4'b0011, 1, 0, "realign_lane0");

        // HUNT mismatch left a slip pending: first bit dropped, then two accepted, then async reset
        step(1, 1, 0, 0, 4'b0011, 0, 0, "pre_rst_drop");
        step(1, 1, 0, 0, 4'b0011, 0, 0, "pre_rst_b0");
        step(1, 0, 0, 0, 4'b0011, 0, 0, "pre_rst_b1");
        din_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk("async_rst", {dout, dout_valid, locked}, 6'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1, 0, 0, 0, 4'b0000, 0, 0, "rst_b0");
        step(1, 1, 0, 0, 4'b0000, 0, 0, "rst_b1");
        step(1, 0, 0, 0, 4'b0000, 0, 0, "rst_b2");
        step(1, 1, 0, 0, 4'b1010, 1, 0, "rst_lane0");

        // slip held for three valid cycles drops exactly one bit
        step(1, 1, 1, 0, 4'b1010, 0, 0, "slip_a");
        step(1, 0, 1, 0, 4'b1010, 0, 0, "slip_drop");
        step(1, 1, 1, 0, 4'b1010, 0, 0, "slip_c");
        step(1, 1, 0, 0, 4'b1010, 0, 0, "slip_d");
        step(1, 0, 0, 0, 4'b0111, 1, 0, "slip_word");

        // CHECK mismatch drops a bit; then a word completing alongside an external slip
        step(1, 1, 0, 0, 4'b0111, 0, 0, "fsm_drop");
        step(1, 0, 0, 0, 4'b0111, 0, 0, "cs_b0");
        step(1, 1, 0, 0, 4'b0111, 0, 0, "cs_b1");
        step(1, 0, 0, 0, 4'b0111, 0, 0, "cs_b2");
        step(1, 1, 1, 0, 4'b1010, 1, 0, "complete_w_slip");
        step(1, 1, 0, 0, 4'b1010, 0, 0, "post_slip_drop");
        step(1, 1, 0, 0, 4'b1010, 0, 0, "ps_b0");
        step(1, 1, 0, 0, 4'b1010, 0, 0, "ps_b1");
        step(1, 0, 0, 0, 4'b1010, 0, 0, "ps_b2");
        step(1, 0, 0, 0, 4'b0011, 1, 0, "ps_word");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
